// File: rtl/mips_boot_pkg.sv
// rtl/mips_boot_pkg.sv - shared loader state encoding and word geometry
package mips_boot_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_BITS      = BYTES_PER_WORD * 8;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        WRITE,
        CSUM,
        DONE,
        ERR
    } boot_state_e;

endpackage

// File: rtl/boot_word_packer.sv
// rtl/boot_word_packer.sv - packs an MSB-first byte stream into instruction words
module boot_word_packer
    import mips_boot_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr,
    input  logic                 push,
    input  logic [7:0]           din,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_full
);

    // Only the first three bytes are stored; the fourth is merged combinationally
    // so the completed word is available on the cycle that byte is accepted.
    logic [1:0]             cnt_q, cnt_d;
    logic [WORD_BITS-9:0]   sr_q, sr_d;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clr) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (push) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {sr_q[WORD_BITS-17:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign word      = {sr_q, din};
    assign word_full = push && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a program image into IMEM and holds the core in reset
// Optional feature: BOOT_CHECKSUM_EN adds a trailing XOR checksum byte check.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int PCWIDTH   = 8,
    parameter int DATAWIDTH = 32,
    parameter int MAX_WORDS = 64
) (
    input  logic                 Clock,
    input  logic                 Reset_,
    input  logic                 Load_Start,
    input  logic                 Rx_Valid,
    input  logic [7:0]           Rx_Data,
    output logic                 Rx_Ready,
    output logic                 Imem_Wen,
    output logic [PCWIDTH-1:0]   Imem_Addr,
    output logic [DATAWIDTH-1:0] Imem_Wdata,
    output logic                 Core_Reset_,
    output logic                 Load_Done,
    output logic                 Load_Err
);

    localparam logic [8:0] MAX_HDR = 9'(MAX_WORDS);

    boot_state_e            state_q, state_d;
    logic [7:0]             n_q, n_d;
    logic [PCWIDTH-3:0]     word_idx_q, word_idx_d;
    logic                   rx_ready_q, rx_ready_d;
    logic                   wen_q, wen_d;
    logic [PCWIDTH-1:0]     addr_q, addr_d;
    logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif

    logic                   rx_fire;
    logic                   pk_clr, pk_push, pk_full;
    logic [WORD_BITS-1:0]   pk_word;
    logic                   last_word;

    assign rx_fire   = Rx_Valid && rx_ready_q;
    assign pk_clr    = (state_q == HDR);
    assign pk_push   = rx_fire && (state_q == LOAD);
    assign last_word = ((8'(word_idx_q) + 8'd1) == n_q);

    boot_word_packer u_packer (
        .clk       (Clock),
        .resetn    (Reset_),
        .clr       (pk_clr),
        .push      (pk_push),
        .din       (Rx_Data),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            HDR: begin
                word_idx_d = '0;
                n_d        = '0;
`ifdef BOOT_CHECKSUM_EN
                csum_d     = '0;
`endif
                if (rx_fire) begin
                    if ((Rx_Data == 8'd0) || ({1'b0, Rx_Data} > MAX_HDR)) begin
                        state_d = ERR;
                    end else begin
                        n_d     = Rx_Data;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (pk_push) begin
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ Rx_Data;
`endif
                    if (pk_full) begin
                        addr_d  = {word_idx_q, 2'b00};
                        wdata_d = pk_word;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                state_d    = last_word ? CSUM : LOAD;
`else
                state_d    = last_word ? DONE : LOAD;
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: begin
                if (rx_fire) begin
                    state_d = (Rx_Data == csum_q) ? DONE : ERR;
                end
            end
`endif
            DONE, ERR: begin
                if (Load_Start) begin
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase

        // Outputs are registered off the next state so they line up with state_q.
        rx_ready_d   = (state_d == HDR) || (state_d == LOAD) || (state_d == CSUM);
        wen_d        = (state_d == WRITE);
        core_rst_n_d = (state_d == DONE);
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERR);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_) begin
            state_q      <= HDR;
            n_q          <= '0;
            word_idx_q   <= '0;
            rx_ready_q   <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_idx_q   <= word_idx_d;
            rx_ready_q   <= rx_ready_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign Rx_Ready    = rx_ready_q;
    assign Imem_Wen    = wen_q;
    assign Imem_Addr   = addr_q;
    assign Imem_Wdata  = wdata_q;
    assign Core_Reset_ = core_rst_n_q;
    assign Load_Done   = done_q;
    assign Load_Err    = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized self-checking bench with a stream-level reference model
module tb_imem_boot_loader;

    localparam int MAX_WORDS = 64;

    logic        Clock = 1'b0;
    logic        Reset_;
    logic        Load_Start;
    logic        Rx_Valid;
    logic [7:0]  Rx_Data;
    logic        Rx_Ready;
    logic        Imem_Wen;
    logic [7:0]  Imem_Addr;
    logic [31:0] Imem_Wdata;
    logic        Core_Reset_;
    logic        Load_Done;
    logic        Load_Err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  stream_q[$];
    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];

    int   ready_viol = 0;
    int   wen_viol   = 0;
    int   core_viol  = 0;
    logic prev_wen   = 1'b0;

    always #5 Clock = ~Clock;

    imem_boot_loader #(.PCWIDTH(8), .DATAWIDTH(32), .MAX_WORDS(MAX_WORDS)) dut (
        .Clock       (Clock),
        .Reset_      (Reset_),
        .Load_Start  (Load_Start),
        .Rx_Valid    (Rx_Valid),
        .Rx_Data     (Rx_Data),
        .Rx_Ready    (Rx_Ready),
        .Imem_Wen    (Imem_Wen),
        .Imem_Addr   (Imem_Addr),
        .Imem_Wdata  (Imem_Wdata),
        .Core_Reset_ (Core_Reset_),
        .Load_Done   (Load_Done),
        .Load_Err    (Load_Err)
    );

    // Write-port observer: every strobe is one IMEM write; strobes never come back to back.
    always @(negedge Clock) begin
        if (Imem_Wen === 1'b1) begin
            got_q.push_back({Imem_Addr, Imem_Wdata});
            if (Rx_Ready !== 1'b0) ready_viol <= ready_viol + 1;
            if (prev_wen === 1'b1) wen_viol <= wen_viol + 1;
        end
        if ((Core_Reset_ === 1'b1) && (Load_Done !== 1'b1)) core_viol <= core_viol + 1;
        prev_wen <= Imem_Wen;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic append_csum(input bit bad);
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 1; i < stream_q.size(); i++) x ^= stream_q[i];
        stream_q.push_back(bad ? (x ^ 8'h01) : x);
`else
        if (bad) stream_q.push_back(8'h00);
        if (bad) void'(stream_q.pop_back());
`endif
    endtask

    task automatic make_stream(input int n, input bit bad);
        stream_q.delete();
        stream_q.push_back(8'(n));
        if (n >= 1 && n <= MAX_WORDS) begin
            for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
            append_csum(bad);
        end
    endtask

    task automatic fixed_stream(input bit bad);
        stream_q = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};
        append_csum(bad);
    endtask

    // Reference: header N, then N big-endian words at 4*i, then an optional XOR byte.
    task automatic model(output int acc, output bit ok);
        int n;
        exp_q.delete();
        n = int'(stream_q[0]);
        if (n == 0 || n > MAX_WORDS) begin
            acc = 1;
            ok  = 1'b0;
            return;
        end
        for (int w = 0; w < n; w++)
            exp_q.push_back({8'(4 * w), stream_q[1+4*w], stream_q[2+4*w],
                             stream_q[3+4*w], stream_q[4+4*w]});
        acc = 1 + 4 * n;
        ok  = 1'b1;
`ifdef BOOT_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int i = 1; i <= 4 * n; i++) x ^= stream_q[i];
            ok  = (stream_q[4*n+1] == x);
            acc = acc + 1;
        end
`endif
    endtask

    // mode 0: always valid, 1: valid toggles each cycle, 2: random valid plus stray Load_Start
    task automatic drive_bytes(input int count, input int mode);
        int idx = 0;
        int cyc = 0;
        bit v, fire;
        while (idx < count && cyc < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            Rx_Valid   = v;
            Rx_Data    = v ? stream_q[idx] : 8'($urandom);
            Load_Start = (mode == 2) && ($urandom_range(0, 7) == 0);
            fire       = v && (Rx_Ready === 1'b1);
            @(posedge Clock); #1;
            if (fire) idx++;
            cyc++;
        end
        Rx_Valid   = 1'b0;
        Load_Start = 1'b0;
        check("bytes_accepted", 64'(idx), 64'(count));
    endtask

    task automatic run_load(input int mode);
        int acc;
        bit ok;
        model(acc, ok);
        got_q.delete();
        drive_bytes(acc, mode);
        for (int i = 0; i < 10 && !(Load_Done === 1'b1 || Load_Err === 1'b1); i++) begin
            @(posedge Clock); #1;
        end
        check("load_done", 64'(Load_Done), 64'(ok));
        check("load_err", 64'(Load_Err), 64'(!ok));
        check("core_reset_n", 64'(Core_Reset_), 64'(ok));
        check("rx_ready_idle", 64'(Rx_Ready), 64'd0);
        check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("write%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        Load_Start = 1'b1;
        @(posedge Clock); #1;
        Load_Start = 1'b0;
        check("restart_core_reset_n", 64'(Core_Reset_), 64'd0);
        check("restart_rx_ready", 64'(Rx_Ready), 64'd1);
        check("restart_flags", 64'({Load_Done, Load_Err}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset_     = 1'b0;
        Load_Start = 1'b0;
        Rx_Valid   = 1'b0;
        Rx_Data    = 8'h00;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_rx_ready", 64'(Rx_Ready), 64'd0);
        check("rst_wen", 64'(Imem_Wen), 64'd0);
        check("rst_addr", 64'(Imem_Addr), 64'd0);
        check("rst_wdata", 64'(Imem_Wdata), 64'd0);
        check("rst_core_reset_n", 64'(Core_Reset_), 64'd0);
        check("rst_flags", 64'({Load_Done, Load_Err}), 64'd0);
        Reset_ = 1'b1;
        @(posedge Clock); #1;
        check("post_rst_rx_ready", 64'(Rx_Ready), 64'd1);
        check("post_rst_core_reset_n", 64'(Core_Reset_), 64'd0);
        check("post_rst_wen", 64'(Imem_Wen), 64'd0);

        fixed_stream(1'b0); run_load(0);
        fixed_stream(1'b0); run_load(1);
        fixed_stream(1'b1); run_load(0);
        fixed_stream(1'b0); run_load(2);

        make_stream(0, 1'b0);    run_load(0);
        make_stream(65, 1'b0);   run_load(2);
        make_stream(255, 1'b0);  run_load(1);
        make_stream(64, 1'b0);   run_load(0);
        make_stream(1, 1'b0);    run_load(1);

        for (int t = 0; t < 10; t++) begin
            make_stream($urandom_range(1, 10), ($urandom_range(0, 3) == 0));
            run_load($urandom_range(0, 2));
        end

        make_stream(2, 1'b0);
        got_q.delete();
        drive_bytes(3, 0);
        Reset_ = 1'b0;
        @(posedge Clock); #1;
        check("midload_rst_rx_ready", 64'(Rx_Ready), 64'd0);
        @(posedge Clock); #1;
        Reset_ = 1'b1;
        @(posedge Clock); #1;
        check("midload_no_write", 64'(got_q.size()), 64'd0);
        check("midload_core_reset_n", 64'(Core_Reset_), 64'd0);
        run_load(0);

        check("rx_ready_during_write", 64'(ready_viol), 64'd0);
        check("wen_single_cycle", 64'(wen_viol), 64'd0);
        check("core_released_only_in_done", 64'(core_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
